// File: rtl/mac_pkg.sv
// Shared definitions for the multi-channel MAC transmit path.
//   arb_state_t   : transmit arbiter frame state (IDLE / PASS / DROP)
//   MAC_MAX_FRAME : default maximum frame length in beats
//   clog2_min1()  : index width that never collapses to zero bits
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } arb_state_t;

  localparam int MAC_MAX_FRAME = 1518;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// Combinational round-robin winner selection for mac_tx_arb.
//   req     in  NUM_PORTS  qualified requests (valid & enable)
//   last    in  PORT_W     index of the most recently finished grant
//   prio_en in  1          port 0 wins outright whenever it requests
//   win_oh  out NUM_PORTS  one-hot winner, all zero when nothing requests
//   win_idx out PORT_W     binary winner index
// The search starts at last+1 and wraps, so the port served last is
// considered last. With prio_en, port 0 is taken first; otherwise the
// remaining ports keep rotating among themselves.
module mac_rr_arb
  import mac_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = clog2_min1(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  input  logic                 prio_en,
  output logic [NUM_PORTS-1:0] win_oh,
  output logic [PORT_W-1:0]    win_idx
);

  logic              found;
  logic [PORT_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    if (prio_en && req[0]) begin
      win_oh[0] = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_PORTS; i++) begin
        cand = PORT_W'((int'(last) + i) % NUM_PORTS);
        if (!found && req[cand]) begin
          found         = 1'b1;
          win_oh[cand]  = 1'b1;
          win_idx       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-granular N-port transmit arbiter. Merges NUM_PORTS AXI-Stream
// sources into one stream without ever interleaving frames, and truncates
// frames longer than MAX_BEATS (forced tlast, remainder dropped).
// Ports:
//   sys_clk, sys_rst                  clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready  per-port slave streams (port p data at [p*DATA_W +: DATA_W])
//   m_axis_tdata/tvalid/tlast/tready  merged master stream (single output register)
//   m_axis_tid                        source port of the beat on the master
//   cfg_port_en                       per-port enable, looked at only when arbitrating
//   stat_trunc, stat_trunc_port       truncation pulse and the port it came from
// Build option: define MAC_TX_ARB_PRIO_EN to give port 0 strict priority at
// arbitration; the default build is pure round-robin.
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BEATS = MAC_MAX_FRAME,
  localparam int PORT_W    = clog2_min1(NUM_PORTS)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [PORT_W-1:0]           m_axis_tid,
  input  logic [NUM_PORTS-1:0]        cfg_port_en,
  output logic                        stat_trunc,
  output logic [PORT_W-1:0]           stat_trunc_port
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

`ifdef MAC_TX_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_t           state;
  logic [PORT_W-1:0]    gnt;
  logic [PORT_W-1:0]    last;
  logic [CNT_W-1:0]     beat_cnt;

  logic [NUM_PORTS-1:0] win_oh;
  logic [PORT_W-1:0]    win_idx;
  logic                 win_any;

  logic [DATA_W-1:0]    tdata_p0;
  logic                 tlast_p0;
  logic                 tvalid_p0;
  logic                 out_rdy;
  logic                 beat_acc;

  logic [DATA_W-1:0]    tdata_p1;
  logic                 tlast_p1;
  logic                 vld_p1;
  logic [PORT_W-1:0]    tid_p1;

  mac_rr_arb #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .req     (s_axis_tvalid & cfg_port_en),
    .last    (last),
    .prio_en (PRIO_EN),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign win_any = |win_oh;

  // Stage p0: select the granted source
  assign tdata_p0  = s_axis_tdata[int'(gnt)*DATA_W +: DATA_W];
  assign tlast_p0  = s_axis_tlast[gnt];
  assign tvalid_p0 = s_axis_tvalid[gnt];

  // Output register can take a beat when empty or draining this cycle.
  assign out_rdy  = !vld_p1 || m_axis_tready;
  assign beat_acc = tvalid_p0 && s_axis_tready[gnt];

  // DROP ignores the master side so a truncated tail never backs up.
  always_comb begin
    s_axis_tready = '0;
    if (state == PASS)      s_axis_tready[gnt] = out_rdy;
    else if (state == DROP) s_axis_tready[gnt] = 1'b1;
  end

  // Stage p1: output register, FSM and frame bookkeeping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= IDLE;
      gnt             <= '0;
      last            <= PORT_W'(NUM_PORTS - 1);
      beat_cnt        <= '0;
      vld_p1          <= 1'b0;
      tdata_p1        <= '0;
      tlast_p1        <= 1'b0;
      tid_p1          <= '0;
      stat_trunc      <= 1'b0;
      stat_trunc_port <= '0;
    end else begin
      stat_trunc <= 1'b0;
      if (vld_p1 && m_axis_tready) vld_p1 <= 1'b0;

      unique case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (win_any) begin
            gnt   <= win_idx;
            state <= PASS;
          end
        end

        PASS: begin
          if (beat_acc) begin
            vld_p1   <= 1'b1;
            tdata_p1 <= tdata_p0;
            tid_p1   <= gnt;
            beat_cnt <= beat_cnt + 1'b1;
            if (tlast_p0) begin
              // A real tlast on beat MAX_BEATS is a normal end.
              tlast_p1 <= 1'b1;
              last     <= gnt;
              state    <= IDLE;
            end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
              tlast_p1        <= 1'b1;
              stat_trunc      <= 1'b1;
              stat_trunc_port <= gnt;
              state           <= DROP;
            end else begin
              tlast_p1 <= 1'b0;
            end
          end
        end

        DROP: begin
          if (beat_acc && tlast_p0) begin
            last  <= gnt;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_p1;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tlast  = tlast_p1;
  assign m_axis_tid    = tid_p1;

endmodule

// File: tb/tb_mac_tx_arb.sv
// Directed bench for mac_tx_arb (NUM_PORTS=4, DATA_W=8, MAX_BEATS=64).
// Source frames are queued per port; the beats each frame should produce on
// the master side are pushed to a scoreboard in the expected grant order and
// popped as the DUT hands them over.
module tb_mac_tx_arb;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int MB = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]  s_tvalid;
  logic [NP-1:0]  s_tlast;
  logic [NP-1:0]  s_tready;
  logic [DW-1:0]  m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic [1:0]     m_tid;
  logic [NP-1:0]  en;
  logic           trunc;
  logic [1:0]     trunc_port;

  always #5 clk = ~clk;

  mac_tx_arb #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .MAX_BEATS (MB)
  ) dut (
    .sys_clk         (clk),
    .sys_rst         (rst),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tready   (m_tready),
    .m_axis_tid      (m_tid),
    .cfg_port_en     (en),
    .stat_trunc      (trunc),
    .stat_trunc_port (trunc_port)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
    logic [1:0]    tid;
  } beat_t;

  beat_t src[NP][$];
  beat_t exp_q[$];
  beat_t held;
  bit    held_v      = 1'b0;
  bit    rnd_rdy     = 1'b0;
  int    dseq        = 0;
  int    trunc_cycles = 0;
  int    checks      = 0;
  int    errors      = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Queue an n-beat frame on port p; optionally push what the master should see.
  task automatic load_frame(input int p, input int n, input bit expect_out);
    for (int i = 1; i <= n; i++) begin
      beat_t b, e;
      b.last = (i == n);
      b.data = DW'(dseq);
      b.tid  = 2'(p);
      dseq++;
      src[p].push_back(b);
      if (expect_out && i <= MB) begin
        e = b;
        if (i == MB) e.last = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (src[p].size() > 0) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*DW +: DW]  = src[p][0].data;
        s_tlast[p]           = src[p][0].last;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tdata[p*DW +: DW]  = '0;
        s_tlast[p]           = 1'b0;
      end
    end
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: drive just after the edge, observe 1 ns later, then wait for the next edge.
  task automatic step();
    beat_t e;
    drive();
    #1;
    if (held_v) begin
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data",  m_tdata,  held.data);
      chk("hold_last",  m_tlast,  held.last);
      chk("hold_tid",   m_tid,    held.tid);
    end
    held_v = m_tvalid && !m_tready;
    held   = {m_tlast, m_tdata, m_tid};
    chk("one_ready", 32'($countones(s_tready) <= 1), 1);
    if (trunc) trunc_cycles++;
    if (m_tvalid && m_tready) begin
      chk("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", m_tdata, e.data);
        chk("out_last", m_tlast, e.last);
        chk("out_tid",  m_tid,   e.tid);
      end
    end
    for (int p = 0; p < NP; p++)
      if (s_tvalid[p] && s_tready[p]) void'(src[p].pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic bit idle();
    bit r;
    r = (exp_q.size() == 0) && !m_tvalid;
    for (int p = 0; p < NP; p++)
      if (en[p] && src[p].size() > 0) r = 1'b0;
    return r;
  endfunction

  task automatic run(input int budget, input string tag);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(idle()), 1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    for (int p = 0; p < NP; p++) src[p].delete();
    exp_q.delete();
    held_v = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_m_tvalid",   m_tvalid,   0);
    chk("rst_m_tdata",    m_tdata,    0);
    chk("rst_m_tlast",    m_tlast,    0);
    chk("rst_m_tid",      m_tid,      0);
    chk("rst_s_tready",   s_tready,   0);
    chk("rst_trunc",      trunc,      0);
    chk("rst_trunc_port", trunc_port, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    en       = 4'hF;
    do_reset();

    // Four ports, one 4-beat frame each: order 0,1,2,3.
    for (int p = 0; p < NP; p++) load_frame(p, 4, 1'b1);
    run(500, "t1");

    // Port 1 three back-to-back frames against one from port 2: order 1,2,1,1.
    do_reset();
    load_frame(1, 5, 1'b1);
    load_frame(2, 3, 1'b1);
    load_frame(1, 2, 1'b1);
    load_frame(1, 1, 1'b1);
    run(500, "t2");

    // Truncation: 68 and 65 beats on port 0, then 65 beats on port 3.
    trunc_cycles = 0;
    load_frame(0, 68, 1'b1);
    load_frame(0, 65, 1'b1);
    run(1000, "t3a");
    chk("t3_trunc_cnt_a",  trunc_cycles, 2);
    chk("t3_trunc_port_a", trunc_port,   0);
    chk("t3_src0_drained", src[0].size(), 0);
    load_frame(3, 65, 1'b1);
    run(1000, "t3b");
    chk("t3_trunc_cnt_b",  trunc_cycles, 3);
    chk("t3_trunc_port_b", trunc_port,   3);

    // 64-beat frame (tlast on the limit beat) with a randomly stalling sink.
    rnd_rdy = 1'b1;
    load_frame(2, 64, 1'b1);
    run(2000, "t4");
    rnd_rdy = 1'b0;
    chk("t4_no_trunc",     trunc_cycles, 3);
    chk("t4_trunc_port",   trunc_port,   3);

    // Port enables: port 2 masked, then port 0 disabled mid-frame.
    do_reset();
    en = 4'b1011;
    load_frame(0, 4, 1'b1);
    load_frame(1, 4, 1'b1);
    load_frame(2, 4, 1'b0);
    load_frame(3, 4, 1'b1);
    run(500, "t5a");
    chk("t5_port2_waiting", src[2].size(), 4);
    src[2].delete();
    en = 4'hF;
    load_frame(0, 8, 1'b1);
    load_frame(1, 4, 1'b1);
    repeat (3) step();
    en = 4'b1110;
    run(500, "t5b");
    load_frame(0, 4, 1'b0);
    load_frame(3, 4, 1'b1);
    run(500, "t5c");
    chk("t5_port0_excluded", src[0].size(), 4);
    src[0].delete();
    en = 4'hF;

    // Port 0 with three frames against ports 1 and 2 with two each.
    do_reset();
`ifdef MAC_TX_ARB_PRIO_EN
    load_frame(0, 2, 1'b1);
    load_frame(0, 2, 1'b1);
    load_frame(0, 2, 1'b1);
    load_frame(1, 2, 1'b1);
    load_frame(2, 2, 1'b1);
    load_frame(1, 2, 1'b1);
    load_frame(2, 2, 1'b1);
`else
    load_frame(0, 2, 1'b1);
    load_frame(1, 2, 1'b1);
    load_frame(2, 2, 1'b1);
    load_frame(0, 2, 1'b1);
    load_frame(1, 2, 1'b1);
    load_frame(2, 2, 1'b1);
    load_frame(0, 2, 1'b1);
`endif
    run(500, "t6a");

    // Reset in the middle of a port 1 frame; port 0 must win first afterwards.
    load_frame(1, 10, 1'b1);
    repeat (5) step();
    do_reset();
    load_frame(0, 3, 1'b1);
    load_frame(3, 3, 1'b1);
    run(500, "t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
